// File: rtl/io_input_conditioner.sv
// -----------------------------------------------------------------------------
// io_input_conditioner
//
// Front end between the board pins and the core's input ports.
//   - Two-flop synchronises the raw active-low push-buttons and the slide
//     switches into i_clk.
//   - Debounces every button independently with a small IDLE/COUNT FSM.
//   - Raises a one-cycle pulse and a sticky event flag on each debounced press.
//     Software clears the sticky flag.
//
// Optional feature, selected with the macro IO_SW_DEBOUNCE_EN:
//   defined   : the switch vector is debounced as a whole by one shared counter.
//   undefined : o_io_sw is the synchronised switch value; no switch counter exists.
//
// Ports
//   i_clk        system clock
//   i_rst        asynchronous reset, active-high
//   i_raw_btn    raw button pins, 0 = pressed, asynchronous
//   i_raw_sw     raw switch pins, asynchronous
//   i_evt_clr    per-bit clear of o_btn_evt, one-cycle pulse
//   o_io_btn     debounced button level, 0 = pressed
//   o_io_sw      conditioned switch value
//   o_btn_press  one-cycle pulse on a debounced press (1->0 of o_io_btn)
//   o_btn_evt    sticky press flag, held until cleared
// -----------------------------------------------------------------------------
module io_input_conditioner #(
  parameter int N_BTN           = 4,
  parameter int N_SW            = 32,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_raw_btn,
  input  logic [N_SW-1:0]  i_raw_sw,
  input  logic [N_BTN-1:0] i_evt_clr,
  output logic [N_BTN-1:0] o_io_btn,
  output logic [N_SW-1:0]  o_io_sw,
  output logic [N_BTN-1:0] o_btn_press,
  output logic [N_BTN-1:0] o_btn_evt
);

  // Derived counter width. It is a localparam so that it cannot be overridden.
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_COUNT
  } btn_state_e;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers. Buttons reset to released (1) and switches to 0.
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] btn_meta_q, btn_sync_q;
  logic [N_SW-1:0]  sw_meta_q,  sw_sync_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the value from before the edge and the two stages shift cleanly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      btn_meta_q <= '1;
      btn_sync_q <= '1;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_meta_q <= i_raw_btn;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= i_raw_sw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-button debounce FSM, press pulse and sticky event.
  // A mismatch that is held continuously moves o_io_btn on the
  // DEBOUNCE_CYCLES-th edge after btn_sync_q first differs:
  //   edge 1 enters COUNT with cnt=1, and the update fires when cnt==LAST.
  // ---------------------------------------------------------------------------
  btn_state_e       state_q [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [N_BTN-1:0] btn_q, press_q, evt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the counter array is real control state, not storage, so it is
      // reset explicitly. A reset in mid-count must not leak a stale count.
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      btn_q   <= '1;
      press_q <= '0;
      evt_q   <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        press_q[i] <= 1'b0;
        // NOTE: the clear is written first and the press set below it. For a
        // set and a clear on the same edge, the later non-blocking write wins,
        // so the set takes priority.
        if (i_evt_clr[i]) evt_q[i] <= 1'b0;

        unique case (state_q[i])
          ST_IDLE: begin
            if (btn_sync_q[i] != btn_q[i]) begin
              state_q[i] <= ST_COUNT;
              cnt_q[i]   <= CNT_ONE;
            end
          end
          ST_COUNT: begin
            if (btn_sync_q[i] == btn_q[i]) begin
              // Glitch: the pin returned before the window expired.
              state_q[i] <= ST_IDLE;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              state_q[i] <= ST_IDLE;
              cnt_q[i]   <= '0;
              btn_q[i]   <= btn_sync_q[i];
              // The new level is the inverse of the old level. An old level of
              // 1 means that this update is a press (1->0).
              if (btn_q[i]) begin
                press_q[i] <= 1'b1;
                evt_q[i]   <= 1'b1;
              end
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
          end
          default: begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign o_io_btn    = btn_q;
  assign o_btn_press = press_q;
  assign o_btn_evt   = evt_q;

  // ---------------------------------------------------------------------------
  // Switch conditioning.
  // ---------------------------------------------------------------------------
`ifdef IO_SW_DEBOUNCE_EN
  // One shared counter for the whole vector. sw_meta_q is the value that
  // sw_sync_q takes on this edge. When they differ, sw_sync_q is changing, and
  // the window restarts from 0 in step with the change. The first stable
  // mismatching edge then counts 1, as the button FSM does.
  logic [CNT_W-1:0] sw_cnt_q;
  logic [N_SW-1:0]  sw_out_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_cnt_q <= '0;
      sw_out_q <= '0;
    end else if (sw_meta_q != sw_sync_q) begin
      sw_cnt_q <= '0;
    end else if (sw_sync_q != sw_out_q) begin
      if (sw_cnt_q == CNT_LAST) begin
        sw_out_q <= sw_sync_q;
        sw_cnt_q <= '0;
      end else begin
        sw_cnt_q <= sw_cnt_q + CNT_ONE;
      end
    end else begin
      sw_cnt_q <= '0;
    end
  end

  assign o_io_sw = sw_out_q;
`else
  assign o_io_sw = sw_sync_q;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_io_input_conditioner
//
// Directed bench for io_input_conditioner with DEBOUNCE_CYCLES = 8.
// The bench changes inputs and samples outputs 1 time unit after a rising edge.
// The bench counts edges from the edge that follows each input change.
// -----------------------------------------------------------------------------
module tb_io_input_conditioner;

  localparam int N_BTN = 4;
  localparam int N_SW  = 32;
  localparam int DBC   = 8;

  localparam logic [31:0] SW_X = 32'hA5A5_0F0F;
  localparam logic [31:0] SW_Y = 32'h1234_5678;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] raw_btn;
  logic [N_SW-1:0]  raw_sw;
  logic [N_BTN-1:0] evt_clr;
  logic [N_BTN-1:0] io_btn;
  logic [N_SW-1:0]  io_sw;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_evt;

  int checks = 0;
  int errors = 0;

  io_input_conditioner #(
    .N_BTN          (N_BTN),
    .N_SW           (N_SW),
    .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_raw_btn  (raw_btn),
    .i_raw_sw   (raw_sw),
    .i_evt_clr  (evt_clr),
    .o_io_btn   (io_btn),
    .o_io_sw    (io_sw),
    .o_btn_press(btn_press),
    .o_btn_evt  (btn_evt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and leave the time 1 unit after the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic early;

    // ---------------- power-on reset ----------------
    rst     = 1'b1;
    raw_btn = 4'hF;
    raw_sw  = '0;
    evt_clr = '0;
    #1;
    check("por_btn", 32'(io_btn), 32'hF);
    check("por_sw", io_sw, 32'h0);
    check("por_evt", 32'(btn_evt), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(1);

    // ---------------- clean press of btn0 ----------------
    raw_btn = 4'b1110;
    tick(DBC + 1);
    check("press0_early_btn", 32'(io_btn), 32'hF);
    check("press0_early_pulse", 32'(btn_press), 32'h0);
    tick(1);
    check("press0_btn", 32'(io_btn), 32'hE);
    check("press0_pulse", 32'(btn_press), 32'h1);
    check("press0_evt", 32'(btn_evt), 32'h1);
    tick(1);
    check("press0_pulse_end", 32'(btn_press), 32'h0);
    check("press0_evt_held", 32'(btn_evt), 32'h1);

    // ---------------- bounce on btn1 ----------------
    early   = 1'b0;
    raw_btn = 4'b1100;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (btn_press[1] || !io_btn[1]) early = 1'b1;
    end
    raw_btn = 4'b1110;
    tick(1);
    if (btn_press[1] || !io_btn[1]) early = 1'b1;
    raw_btn = 4'b1100;
    for (int i = 0; i < DBC + 1; i++) begin
      tick(1);
      if (btn_press[1] || !io_btn[1]) early = 1'b1;
    end
    check("bounce_no_early", 32'(early), 32'h0);
    tick(1);
    check("bounce_btn", 32'(io_btn), 32'hC);
    check("bounce_pulse", 32'(btn_press), 32'h2);
    check("bounce_evt", 32'(btn_evt), 32'h3);
    tick(20 - (DBC + 2));
    check("bounce_pulse_once", 32'(btn_press), 32'h0);
    evt_clr = 4'b0011;
    tick(1);
    evt_clr = 4'b0000;
    check("clr01_evt", 32'(btn_evt), 32'h0);

    // ---------------- sticky / clear on btn2 ----------------
    raw_btn = 4'b1000;
    tick(DBC + 2);
    check("press2_btn", 32'(io_btn), 32'h8);
    check("press2_evt", 32'(btn_evt), 32'h4);
    raw_btn = 4'b1100;                       // release btn2
    tick(DBC + 2);
    check("release2_btn", 32'(io_btn), 32'hC);
    check("release2_no_pulse", 32'(btn_press), 32'h0);
    evt_clr = 4'b0100;
    tick(1);
    evt_clr = 4'b0000;
    check("clr2_alone_a", 32'(btn_evt), 32'h0);
    raw_btn = 4'b1000;                       // press btn2 again
    tick(DBC + 1);
    evt_clr = 4'b0100;                       // clear lands on the press edge
    tick(1);
    evt_clr = 4'b0000;
    check("set_wins_evt", 32'(btn_evt), 32'h4);
    check("set_wins_pulse", 32'(btn_press), 32'h4);
    evt_clr = 4'b0001;                       // clear an already-0 bit
    tick(1);
    evt_clr = 4'b0000;
    check("clr_noop_evt", 32'(btn_evt), 32'h4);
    evt_clr = 4'b0100;
    tick(1);
    evt_clr = 4'b0000;
    check("clr2_alone_b", 32'(btn_evt), 32'h0);

    // ---------------- release btn0 while pressing btn3 ----------------
    raw_btn = 4'b0001;
    tick(DBC + 1);
    check("multi_early_btn", 32'(io_btn), 32'h8);
    tick(1);
    check("multi_btn", 32'(io_btn), 32'h1);
    check("multi_pulse", 32'(btn_press), 32'h8);
    check("multi_evt", 32'(btn_evt), 32'h8);

    // ---------------- switches ----------------
`ifdef IO_SW_DEBOUNCE_EN
    raw_sw = SW_X;
    tick(DBC + 1);
    check("sw_db_early", io_sw, 32'h0);
    tick(1);
    check("sw_db_x", io_sw, SW_X);
    raw_sw = SW_Y;
    tick(4);
    raw_sw = '0;                             // 3-cycle glitch
    tick(3);
    raw_sw = SW_Y;
    tick(DBC + 1);
    check("sw_glitch_hold", io_sw, SW_X);
    tick(1);
    check("sw_glitch_y", io_sw, SW_Y);
`else
    raw_sw = SW_X;
    tick(1);
    check("sw_one_edge", io_sw, 32'h0);
    tick(1);
    check("sw_x", io_sw, SW_X);
    raw_sw = SW_Y;
    tick(2);
    check("sw_y", io_sw, SW_Y);
`endif

    // ---------------- asynchronous reset mid-debounce ----------------
    raw_btn = 4'($urandom) & 4'b0111;        // at least btn3 stays pressed
    raw_sw  = $urandom | 32'h1;
    tick(4);
    #3;
    rst = 1'b1;
    #1;
    check("rst_btn", 32'(io_btn), 32'hF);
    check("rst_sw", io_sw, 32'h0);
    check("rst_evt", 32'(btn_evt), 32'h0);
    check("rst_pulse", 32'(btn_press), 32'h0);
    raw_btn = 4'hF;
    raw_sw  = '0;
    tick(1);
    rst   = 1'b0;
    early = 1'b0;
    for (int i = 0; i < DBC + 4; i++) begin
      tick(1);
      if (btn_press != 4'h0 || btn_evt != 4'h0 || io_btn != 4'hF) early = 1'b1;
    end
    check("rst_no_event", 32'(early), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
